// File: rtl/s_intr_pkg.sv
// s_intr_pkg: FSM state encoding and ID-width helper for the slow-domain interrupt controller
package s_intr_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;
  function automatic int intr_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/s_intr_prio_enc.sv
// s_intr_prio_enc: combinational lowest-index priority encoder
module s_intr_prio_enc #(
  parameter int W  = 1,
  parameter int IW = 1
) (
  input  logic [W-1:0]  vec,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) if (vec[i]) idx = IW'(i);
  end
  assign any = |vec;
endmodule

// File: rtl/s_intr_pending_ctrl.sv
// s_intr_pending_ctrl: latches interrupt pulses, offers lowest eligible source, tracks in-service
// optional per-source coalesced-event counters enabled by INTR_PEND_OVF_CNT_EN
module s_intr_pending_ctrl
  import s_intr_pkg::*;
#(
  parameter int INTR_WIDTH = 1,
  parameter int CNT_WIDTH  = 4,
  localparam int ID_W      = intr_id_w(INTR_WIDTH)
) (
  input  logic                  slow_clk,
  input  logic                  slow_rst,
  input  logic [INTR_WIDTH-1:0] intr_pulse,
  input  logic [INTR_WIDTH-1:0] intr_en,
  output logic                  irq_valid,
  output logic [ID_W-1:0]       irq_id,
  input  logic                  irq_ready,
  input  logic                  cmpl_valid,
  input  logic [ID_W-1:0]       cmpl_id,
  output logic [INTR_WIDTH-1:0] pending,
  output logic [INTR_WIDTH-1:0] in_service
`ifdef INTR_PEND_OVF_CNT_EN
  ,output logic [INTR_WIDTH*CNT_WIDTH-1:0] ovf_cnt
`endif
);
  state_t state, state_nxt;
  logic any, claim;
  logic [ID_W-1:0] sel;
  logic [INTR_WIDTH-1:0] eligible, id_vec, cmpl_vec, claim_vec;
  assign eligible = pending & intr_en & ~in_service;
  s_intr_prio_enc #(.W(INTR_WIDTH), .IW(ID_W)) u_enc (.vec(eligible), .any(any), .idx(sel));
  always_comb begin
    id_vec = '0;
    cmpl_vec = '0;
    for (int i = 0; i < INTR_WIDTH; i++) begin
      id_vec[i] = irq_id == ID_W'(i);
      cmpl_vec[i] = cmpl_valid && cmpl_id == ID_W'(i);
    end
  end
  assign irq_valid = state == ST_OFFER;
  assign claim = irq_valid && irq_ready;
  assign claim_vec = claim ? id_vec : '0;
  always_comb begin
    state_nxt = state == ST_IDLE ? (any ? ST_OFFER : ST_IDLE)
              : (irq_ready || ~|(id_vec & intr_en)) ? ST_IDLE : ST_OFFER;
  end
  always_ff @(posedge slow_clk) begin
    if (slow_rst) begin
      state <= ST_IDLE;
      pending <= '0;
      in_service <= '0;
      irq_id <= '0;
    end else begin
      state <= state_nxt;
      pending <= (pending & ~claim_vec) | intr_pulse;
      in_service <= (in_service & ~cmpl_vec) | claim_vec;
      if (state == ST_IDLE && any) irq_id <= sel;
    end
  end
`ifdef INTR_PEND_OVF_CNT_EN
  logic [INTR_WIDTH-1:0][CNT_WIDTH-1:0] cnt;
  assign ovf_cnt = cnt;
  // a pulse landing on an already-pending bit is a lost event unless the same cycle claims it
  always_ff @(posedge slow_clk) begin
    for (int i = 0; i < INTR_WIDTH; i++)
      if (slow_rst) cnt[i] <= '0;
      else if (intr_pulse[i] && pending[i] && !claim_vec[i] && ~&cnt[i]) cnt[i] <= cnt[i] + 1'b1;
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = CNT_WIDTH[0];
`endif
endmodule

// File: tb/tb_s_intr_pending_ctrl.sv
// tb_s_intr_pending_ctrl: directed self-checking bench, INTR_WIDTH=4, CNT_WIDTH=2
module tb_s_intr_pending_ctrl;
  logic slow_clk = 1'b0;
  logic slow_rst = 1'b1;
  logic [3:0] intr_pulse = '0, intr_en = 4'hF, pending, in_service;
  logic irq_valid, irq_ready = 1'b0, cmpl_valid = 1'b0;
  logic [1:0] irq_id, cmpl_id = '0;
  int n_pass = 0, n_total = 0;
`ifdef INTR_PEND_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif
  always #5 slow_clk = ~slow_clk;
  s_intr_pending_ctrl #(.INTR_WIDTH(4), .CNT_WIDTH(2)) dut (
    .slow_clk(slow_clk), .slow_rst(slow_rst), .intr_pulse(intr_pulse), .intr_en(intr_en),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready), .cmpl_valid(cmpl_valid),
    .cmpl_id(cmpl_id), .pending(pending), .in_service(in_service)
`ifdef INTR_PEND_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );
  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    tick(); tick();
    slow_rst = 1'b0;
    chk("rst_valid", 8'(irq_valid), 8'd0);
    chk("rst_id", 8'(irq_id), 8'd0);
    chk("rst_pend", 8'(pending), 8'h0);
    chk("rst_insvc", 8'(in_service), 8'h0);
    // single pulse on src 2
    intr_pulse = 4'b0100; tick(); intr_pulse = '0;
    chk("lat_pend", 8'(pending), 8'h4);
    chk("lat_valid_n1", 8'(irq_valid), 8'd0);
    tick();
    chk("lat_valid_n2", 8'(irq_valid), 8'd1);
    chk("lat_id", 8'(irq_id), 8'd2);
    irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    chk("claim2_valid", 8'(irq_valid), 8'd0);
    chk("claim2_pend", 8'(pending), 8'h0);
    chk("claim2_insvc", 8'(in_service), 8'h4);
    cmpl_valid = 1'b1; cmpl_id = 2'd2; tick(); cmpl_valid = 1'b0;
    chk("cmpl2_insvc", 8'(in_service), 8'h0);
    // simultaneous pulses on 1 and 3, ready held high
    intr_pulse = 4'b1010; irq_ready = 1'b1; tick(); intr_pulse = '0;
    chk("dual_pend", 8'(pending), 8'hA);
    tick();
    chk("dual_id1", 8'(irq_id), 8'd1);
    chk("dual_v1", 8'(irq_valid), 8'd1);
    tick();
    chk("dual_gap", 8'(irq_valid), 8'd0);
    tick();
    chk("dual_id3", 8'(irq_id), 8'd3);
    chk("dual_v3", 8'(irq_valid), 8'd1);
    tick(); irq_ready = 1'b0;
    chk("dual_insvc", 8'(in_service), 8'hA);
    chk("dual_pend0", 8'(pending), 8'h0);
    cmpl_valid = 1'b1; cmpl_id = 2'd1; tick(); cmpl_id = 2'd3; tick(); cmpl_id = 2'd0; tick();
    cmpl_valid = 1'b0;
    chk("dual_cmpl", 8'(in_service), 8'h0);
    // withdraw by disabling the offered source
    intr_pulse = 4'b0001; tick(); intr_pulse = '0; tick();
    chk("wd_offer", 8'({irq_valid, irq_id}), 8'h4);
    intr_en = 4'b1110; tick();
    chk("wd_valid", 8'(irq_valid), 8'd0);
    chk("wd_pend", 8'(pending), 8'h1);
    tick();
    chk("wd_idle", 8'(irq_valid), 8'd0);
    intr_en = 4'hF; tick();
    chk("wd_reoffer", 8'({irq_valid, irq_id}), 8'h4);
    irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    cmpl_valid = 1'b1; cmpl_id = 2'd0; tick(); cmpl_valid = 1'b0;
    chk("wd_done", 8'({pending, in_service}), 8'h00);
    // claim with simultaneous re-pulse: stays pending but not re-offered while in service
    intr_pulse = 4'b0010; tick(); intr_pulse = '0; tick();
    chk("rp_offer", 8'({irq_valid, irq_id}), 8'h5);
    irq_ready = 1'b1; intr_pulse = 4'b0010; tick(); irq_ready = 1'b0; intr_pulse = '0;
    chk("rp_pend", 8'(pending), 8'h2);
    chk("rp_insvc", 8'(in_service), 8'h2);
`ifdef INTR_PEND_OVF_CNT_EN
    chk("rp_ovf", ovf_cnt, 8'h00);
`endif
    tick(); tick();
    chk("rp_noreoffer", 8'(irq_valid), 8'd0);
    cmpl_valid = 1'b1; cmpl_id = 2'd1; tick(); cmpl_valid = 1'b0;
    chk("rp_cmpl", 8'(in_service), 8'h0);
    chk("rp_cmpl_v", 8'(irq_valid), 8'd0);
    tick();
    chk("rp_again", 8'({irq_valid, irq_id}), 8'h5);
    irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    // completion and pulse of same source together
    cmpl_valid = 1'b1; cmpl_id = 2'd1; intr_pulse = 4'b0010; tick();
    cmpl_valid = 1'b0; intr_pulse = '0;
    chk("cp_both", 8'({pending, in_service}), 8'h20);
    tick(); irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    chk("cp_claim", 8'(in_service), 8'h2);
    // reset during an offer
    intr_pulse = 4'b1000; tick(); intr_pulse = '0; tick();
    chk("rs_offer", 8'({irq_valid, irq_id}), 8'h7);
    slow_rst = 1'b1; irq_ready = 1'b1; tick(); slow_rst = 1'b0; irq_ready = 1'b0;
    chk("rs_valid", 8'(irq_valid), 8'd0);
    chk("rs_state", 8'({pending, in_service}), 8'h00);
    chk("rs_id", 8'(irq_id), 8'd0);
`ifdef INTR_PEND_OVF_CNT_EN
    intr_en = 4'h0;
    intr_pulse = 4'b0001; tick(); tick(); tick();
    chk("ovf_2", ovf_cnt, 8'h02);
    tick(); tick(); tick(); intr_pulse = '0;
    chk("ovf_sat", ovf_cnt, 8'h03);
    intr_en = 4'hF;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
